ship_command_scheduler: RTL and testbench
=========================================

Name: ship_command_scheduler

Overview:
- Sequences held-key levels from the PS/2 keyboard tracker (hold mode) into frame-aligned game commands for the ship datapath.
- Owns game mode (ATTRACT / PLAY / PAUSE), resolves conflicting keys, and rate-limits firing through a cooldown counter.
- Issues fire requests to the bullet spawner over a req/ack handshake.
- Sits between the keyboard tracker and the ship/bullet update logic, all in the system clock domain.

Parameters:
- FIRE_COOLDOWN, 8: frames between accepted shots (1..255).
- CD_W, 8: cooldown counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- key_left  in  1  level; left arrow held
- key_right  in  1  level; right arrow held
- key_up  in  1  level; thrust key held
- key_space  in  1  level; fire key held
- key_enter  in  1  level; start/pause key held
- game_over  in  1  one-cycle pulse from game logic
- fire_ack  in  1  one-cycle pulse; spawner accepted the shot
- rot_ccw  out  1  one-cycle pulse, coincident with frame_tick+1
- rot_cw  out  1  one-cycle pulse, coincident with frame_tick+1
- thrust  out  1  one-cycle pulse, coincident with frame_tick+1
- fire_req  out  1  level; held until fire_ack
- game_start  out  1  one-cycle pulse on ATTRACT->PLAY
- paused  out  1  level; high in PAUSE
- mode  out  2  00 ATTRACT, 01 PLAY, 10 PAUSE

Behaviour:
- Reset values:
  - mode=ATTRACT; all pulses 0; fire_req 0; paused 0.
  - cooldown=0; enter edge register = 1, so an enter key held through reset does not count as a press.
- Enter edge: enter_rise = key_enter & ~enter_q; enter_q is registered every cycle.
- State machine, evaluated every cycle:
  - ATTRACT: enter_rise -> PLAY, with game_start=1 for one cycle and cooldown cleared.
  - PLAY: game_over -> ATTRACT (takes priority); otherwise enter_rise -> PAUSE.
  - PAUSE: game_over -> ATTRACT; otherwise enter_rise -> PLAY. The cooldown counter is frozen.
- Motion commands:
  - Registered one cycle after frame_tick, only when mode==PLAY on the frame_tick cycle.
  - rot_ccw = key_left & ~key_right; rot_cw = key_right & ~key_left. Both keys held gives no rotation.
  - thrust = key_up. Each is a single-cycle pulse.
- Cooldown:
  - On each frame_tick in PLAY with cooldown>0, decrement by 1 and saturate at 0.
  - On fire_ack, load FIRE_COOLDOWN. If fire_ack and the decrement coincide, the load wins.
- Fire request:
  - Set on a frame_tick in PLAY when key_space=1, cooldown==0 and fire_req==0.
  - Held high until fire_ack, which clears it in the next cycle.
  - A fire_ack while fire_req==0 is ignored and does not load the cooldown.
- Holding space auto-fires: one request every FIRE_COOLDOWN+1 frames when fire_ack comes back immediately.
- Leaving PLAY (to PAUSE or ATTRACT) drops fire_req in the same cycle as the mode change, with no cooldown load. A fire_ack arriving in that cycle is ignored.
- paused = (mode==PAUSE), registered.
- Reset asserted mid-operation: all state returns to reset values on the next edge; pulses in flight are discarded.
- Latency: frame_tick to command pulse = 1 cycle. frame_tick to fire_req rise = 1 cycle.

Optional Feature:
- Macro: HYPERSPACE_EN.
- With the macro defined:
  - Adds input key_down and output hyperspace (a one-cycle pulse).
  - In PLAY, a rising edge of key_down arms a request; the hyperspace pulse is emitted on the next frame_tick+1, then a 64-frame lockout counter starts.
  - Edges during the lockout are dropped.
  - Leaving PLAY or reset clears the armed request and the lockout.
- Without the macro: the port and all related logic are absent.

Test Plan:
- Reset held 3 cycles with key_enter=1, then released with enter still held -> mode stays 00 and game_start never pulses. Enter low for 1 cycle, then high -> mode=01 and game_start=1 for exactly 1 cycle.
- PLAY, key_left=1 and key_right=1 across 4 frame_ticks -> rot_cw=rot_ccw=0. Release right -> rot_ccw pulses once per tick, 1 cycle after each tick.
- PLAY, space held, fire_ack returned 2 cycles after each fire_req rise, FIRE_COOLDOWN=8 -> fire_req rises on frames 0, 9, 18. Exactly 3 acks over 20 frames.
- PLAY with fire_req pending, enter pressed -> mode=10, paused=1, fire_req=0 in the same cycle. frame_ticks in PAUSE produce no pulses and the cooldown value is unchanged.
- game_over and enter_rise in the same cycle during PAUSE -> mode=00 and no game_start.
- HYPERSPACE_EN defined, key_down pressed twice 10 frames apart -> exactly one hyperspace pulse. A third press at frame 70 -> a second pulse.

Source files
------------

// File: rtl/ship_command_scheduler.sv
// ship_command_scheduler
// Turns held-key levels into frame-aligned ship commands, owns the game mode
// (ATTRACT / PLAY / PAUSE) and rate-limits firing with a frame cooldown.
// Fire requests go to the bullet spawner over a level req / pulse ack handshake.
// Optional feature macro: HYPERSPACE_EN (adds key_down input, hyperspace output).
module ship_command_scheduler #(
  parameter int FIRE_COOLDOWN = 8,
  parameter int CD_W          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_space,
  input  logic       key_enter,
  input  logic       game_over,
  input  logic       fire_ack,
`ifdef HYPERSPACE_EN
  input  logic       key_down,
  output logic       hyperspace,
`endif
  output logic       rot_ccw,
  output logic       rot_cw,
  output logic       thrust,
  output logic       fire_req,
  output logic       game_start,
  output logic       paused,
  output logic [1:0] mode
);

  localparam logic [1:0]      MODE_ATTRACT = 2'b00;
  localparam logic [1:0]      MODE_PLAY    = 2'b01;
  localparam logic [1:0]      MODE_PAUSE   = 2'b10;
  localparam logic [CD_W-1:0] CD_LOAD      = CD_W'(FIRE_COOLDOWN);

  logic [1:0]      mode_q, mode_d;
  logic            enter_q;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            fire_req_q, fire_req_d;
  logic            rot_ccw_q, rot_cw_q, thrust_q, game_start_q, paused_q;
  logic            enter_rise, in_play, frame_play, start_play, leave_play;

  // enter_q resets high so a key held through reset is not seen as a press
  assign enter_rise = key_enter & ~enter_q;
  assign in_play    = (mode_q == MODE_PLAY);
  assign frame_play = in_play & frame_tick;
  assign start_play = (mode_q == MODE_ATTRACT) & (mode_d == MODE_PLAY);
  assign leave_play = in_play & (mode_d != MODE_PLAY);

  // Mode transitions; game_over outranks a simultaneous enter press
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_ATTRACT: if (enter_rise) mode_d = MODE_PLAY;
      MODE_PLAY: begin
        if (game_over)       mode_d = MODE_ATTRACT;
        else if (enter_rise) mode_d = MODE_PAUSE;
      end
      MODE_PAUSE: begin
        if (game_over)       mode_d = MODE_ATTRACT;
        else if (enter_rise) mode_d = MODE_PLAY;
      end
      default: mode_d = MODE_ATTRACT;
    endcase
  end

  // Cooldown and fire request; an ack load beats the per-frame decrement,
  // and leaving PLAY drops the request without loading the cooldown
  always_comb begin
    cd_d       = cd_q;
    fire_req_d = fire_req_q;
    if (frame_play && cd_q != '0)
      cd_d = cd_q - CD_W'(1);
    if (in_play && !leave_play && fire_req_q && fire_ack) begin
      cd_d       = CD_LOAD;
      fire_req_d = 1'b0;
    end
    if (frame_play && key_space && cd_q == '0 && !fire_req_q)
      fire_req_d = 1'b1;
    if (mode_d != MODE_PLAY)
      fire_req_d = 1'b0;
    if (start_play)
      cd_d = '0;
  end

  // Control state and single-cycle command pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q       <= MODE_ATTRACT;
      enter_q      <= 1'b1;
      cd_q         <= '0;
      fire_req_q   <= 1'b0;
      rot_ccw_q    <= 1'b0;
      rot_cw_q     <= 1'b0;
      thrust_q     <= 1'b0;
      game_start_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      enter_q      <= key_enter;
      cd_q         <= cd_d;
      fire_req_q   <= fire_req_d;
      rot_ccw_q    <= frame_play & key_left & ~key_right;
      rot_cw_q     <= frame_play & key_right & ~key_left;
      thrust_q     <= frame_play & key_up;
      game_start_q <= start_play;
      paused_q     <= (mode_d == MODE_PAUSE);
    end
  end

  assign rot_ccw    = rot_ccw_q;
  assign rot_cw     = rot_cw_q;
  assign thrust     = thrust_q;
  assign fire_req   = fire_req_q;
  assign game_start = game_start_q;
  assign paused     = paused_q;
  assign mode       = mode_q;

`ifdef HYPERSPACE_EN
  logic       down_q, armed_q, armed_d, hyper_q;
  logic [6:0] lock_q, lock_d;
  logic       down_rise;

  assign down_rise = key_down & ~down_q;

  // Arm on a key_down press, jump on the next frame, then lock out 64 frames
  always_comb begin
    armed_d = armed_q;
    lock_d  = lock_q;
    if (frame_play && lock_q != '0)
      lock_d = lock_q - 7'd1;
    if (frame_play && armed_q) begin
      armed_d = 1'b0;
      lock_d  = 7'd64;
    end else if (in_play && down_rise && lock_q == '0) begin
      armed_d = 1'b1;
    end
    if (mode_d != MODE_PLAY) begin
      armed_d = 1'b0;
      lock_d  = '0;
    end
  end

  // Hyperspace request state and output pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      down_q  <= 1'b1;
      armed_q <= 1'b0;
      lock_q  <= '0;
      hyper_q <= 1'b0;
    end else begin
      down_q  <= key_down;
      armed_q <= armed_d;
      lock_q  <= lock_d;
      hyper_q <= frame_play & armed_q;
    end
  end

  assign hyperspace = hyper_q;
`else
  // Base build: no hyperspace key, no lockout state.
`endif

endmodule

// File: tb/tb_ship_command_scheduler.sv
// Self-checking bench for ship_command_scheduler: directed scenarios plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_ship_command_scheduler;

  localparam int FIRE_COOLDOWN = 8;

  logic clock = 1'b0;
  logic reset, frame_tick, key_left, key_right, key_up, key_space, key_enter;
  logic game_over, fire_ack;
  logic rot_ccw, rot_cw, thrust, fire_req, game_start, paused;
  logic [1:0] mode;
`ifdef HYPERSPACE_EN
  logic key_down, hyperspace;
  int   hyp_cnt = 0;
`endif

  always #5 clock = ~clock;

  ship_command_scheduler #(.FIRE_COOLDOWN(FIRE_COOLDOWN), .CD_W(8)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_space(key_space), .key_enter(key_enter), .game_over(game_over),
    .fire_ack(fire_ack),
`ifdef HYPERSPACE_EN
    .key_down(key_down), .hyperspace(hyperspace),
`endif
    .rot_ccw(rot_ccw), .rot_cw(rot_cw), .thrust(thrust), .fire_req(fire_req),
    .game_start(game_start), .paused(paused), .mode(mode)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: 0 = ATTRACT, 1 = PLAY, 2 = PAUSE
  int m_mode = 0, m_cd = 0;
  bit m_enter_prev = 1, m_req = 0;
  bit e_ccw = 0, e_cw = 0, e_thr = 0, e_gs = 0, e_paused = 0;

  task automatic model_update();
    int  nmode, ncd;
    bit  rise, nreq, ticking_play;
    if (reset) begin
      m_mode = 0; m_enter_prev = 1; m_cd = 0; m_req = 0;
      e_ccw = 0; e_cw = 0; e_thr = 0; e_gs = 0; e_paused = 0;
      return;
    end
    rise  = key_enter && !m_enter_prev;
    nmode = m_mode;
    if (m_mode == 0 && rise) nmode = 1;
    else if (m_mode != 0 && game_over) nmode = 0;
    else if (m_mode != 0 && rise) nmode = (m_mode == 1) ? 2 : 1;
    ticking_play = frame_tick && (m_mode == 1);
    e_ccw = ticking_play && key_left && !key_right;
    e_cw  = ticking_play && key_right && !key_left;
    e_thr = ticking_play && key_up;
    ncd  = m_cd;
    nreq = m_req;
    if (ticking_play && m_cd > 0) ncd = m_cd - 1;
    if (m_mode == 1 && nmode == 1 && m_req && fire_ack) begin
      ncd = FIRE_COOLDOWN; nreq = 0;
    end
    if (ticking_play && key_space && m_cd == 0 && !m_req) nreq = 1;
    if (nmode != 1) nreq = 0;
    e_gs = (m_mode == 0 && nmode == 1);
    if (e_gs) ncd = 0;
    e_paused = (nmode == 2);
    m_mode = nmode; m_cd = ncd; m_req = nreq; m_enter_prev = key_enter;
  endtask

  int cnt_ccw = 0, cnt_cw = 0, cnt_thr = 0;

  // One clock: inputs already driven; update model, sample at next negedge
  task automatic step();
    model_update();
    @(negedge clock);
    check("mode", mode, m_mode);
    check("paused", paused, e_paused);
    check("game_start", game_start, e_gs);
    check("rot_ccw", rot_ccw, e_ccw);
    check("rot_cw", rot_cw, e_cw);
    check("thrust", thrust, e_thr);
    check("fire_req", fire_req, m_req);
    cnt_ccw += rot_ccw; cnt_cw += rot_cw; cnt_thr += thrust;
`ifdef HYPERSPACE_EN
    hyp_cnt += hyperspace;
`endif
  endtask

  task automatic frame();
    frame_tick = 1; step();
    frame_tick = 0; repeat (4) step();
  endtask

  task automatic press_enter();
    key_enter = 0; step();
    key_enter = 1; step();
  endtask

  initial begin
    int rises[$];
    int acks, since, period, tcnt, ackdly;
    bit prev_req;
    reset = 1; frame_tick = 0; key_left = 0; key_right = 0; key_up = 0;
    key_space = 0; key_enter = 1; game_over = 0; fire_ack = 0;
`ifdef HYPERSPACE_EN
    key_down = 0;
`endif
    // Enter held through reset must not start the game
    repeat (3) step();
    reset = 0;
    repeat (4) step();
    check("enter_held_mode", mode, 0);
    key_enter = 0; step();
    key_enter = 1; step();
    check("start_mode", mode, 1);
    check("start_pulse", game_start, 1);
    step();
    check("start_once", game_start, 0);

    // Both arrows held: no rotation; then left only rotates once per frame
    key_left = 1; key_right = 1; cnt_ccw = 0; cnt_cw = 0;
    repeat (4) frame();
    check("both_ccw", cnt_ccw, 0);
    check("both_cw", cnt_cw, 0);
    key_right = 0;
    repeat (3) frame();
    check("left_ccw", cnt_ccw, 3);
    key_left = 0;

    // Auto-fire with ack two cycles after each request rise
    key_space = 1; acks = 0; since = 100; prev_req = 0;
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < 5; c++) begin
        since++;
        frame_tick = (c == 0);
        fire_ack = (since == 2);
        step();
        if (fire_ack) acks++;
        if (fire_req && !prev_req) begin rises.push_back(f); since = 0; end
        prev_req = fire_req;
      end
    end
    fire_ack = 0;
    check("auto_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      check("rise0", rises[0], 0);
      check("rise1", rises[1], 9);
      check("rise2", rises[2], 18);
    end
    check("auto_acks", acks, 3);

    // Pending request dropped on pause; no pulses while paused
    for (int f = 0; f < 12; f++) begin
      frame();
      if (fire_req) break;
    end
    check("pend_req", fire_req, 1);
    key_enter = 0; step();
    key_enter = 1; step();
    check("pause_mode", mode, 2);
    check("pause_flag", paused, 1);
    check("pause_req", fire_req, 0);
    key_left = 1; key_up = 1; cnt_ccw = 0; cnt_thr = 0;
    repeat (3) frame();
    check("pause_ccw", cnt_ccw, 0);
    check("pause_thr", cnt_thr, 0);
    check("pause_req_hold", fire_req, 0);
    key_left = 0; key_up = 0;
    press_enter();
    check("resume_mode", mode, 1);
    frame();

    // game_over wins over enter in PAUSE and does not start a game
    press_enter();
    check("pause2_mode", mode, 2);
    key_enter = 0; step();
    key_enter = 1; game_over = 1; step();
    game_over = 0;
    check("over_mode", mode, 0);
    check("over_start", game_start, 0);
    key_space = 0;

`ifdef HYPERSPACE_EN
    // Second press inside the lockout is dropped; third press after it fires
    reset = 1; step(); reset = 0; step();
    press_enter();
    hyp_cnt = 0;
    for (int f = 0; f < 80; f++) begin
      for (int c = 0; c < 5; c++) begin
        frame_tick = (c == 0);
        if (c == 1 && (f == 0 || f == 10 || f == 70)) key_down = 1;
        if (c == 3) key_down = 0;
        step();
      end
      if (f == 20) check("hyp_first", hyp_cnt, 1);
    end
    check("hyp_total", hyp_cnt, 2);
`endif

    // Randomized phase against the model
    period = 4; tcnt = 0; ackdly = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      tcnt++;
      frame_tick = 0;
      if (tcnt >= period) begin
        frame_tick = 1; tcnt = 0; period = $urandom_range(2, 6);
      end
      if ($urandom_range(0, 39) == 0) key_enter = ~key_enter;
      game_over = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) key_left  = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) key_right = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) key_up    = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) key_space = ($urandom_range(0, 3) != 0);
      if (m_req) begin
        if (ackdly == 0) fire_ack = 1;
        else begin fire_ack = 0; ackdly--; end
      end else begin
        fire_ack = ($urandom_range(0, 49) == 0);
        ackdly = $urandom_range(0, 3);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
